// File: rtl/ipml_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ipml_fifo_pkg
// Shared definitions for the ipml single-clock FIFO family.
//   MODE_STD / MODE_FWFT : legal values of the c_MODE parameter
//   level_width()        : width of a counter that must hold 0..2^depth_width
// ----------------------------------------------------------------------------
package ipml_fifo_pkg;

    localparam string MODE_STD  = "STD";
    localparam string MODE_FWFT = "FWFT";

    // A level counter must represent DEPTH itself, hence one extra bit.
    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/ipml_sync_fifo_ram.sv
// ----------------------------------------------------------------------------
// ipml_sync_fifo_ram
// Simple dual-port RAM, one write port and one read port on the same clock.
// The read port has a single registered output stage (1-cycle latency) that
// is cleared by rst_i (asynchronous) or clr_i (synchronous) and only changes
// when re_i is high. No read-during-write bypass: the FIFO control never
// reads the address being written on the same edge.
//   clk_i    clock
//   rst_i    asynchronous active-high reset of the output register
//   clr_i    synchronous clear of the output register
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable (loads the output register)
//   raddr_i  read address
//   rdata_o  registered read data
// ----------------------------------------------------------------------------
module ipml_sync_fifo_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ipml_sync_fifo_v2.sv
// ----------------------------------------------------------------------------
// ipml_sync_fifo_v2
// Single-clock FIFO with standard or first-word-fall-through read mode.
// Handshake: a write is taken when wr_en && !wr_full, a read (STD) or head
// acknowledge (FWFT) is taken when rd_en && !rd_empty; both use the flags
// registered in the current cycle, so no output depends combinationally on
// wr_en or rd_en.
//   clk, rst, clr        clock, async reset, synchronous flush
//   wr_data, wr_en       write side
//   wr_full, almost_full, overflow      write-side status (registered)
//   rd_data, rd_en       read side
//   rd_empty, almost_empty, underflow   read-side status (registered)
//   water_level          words held, including the FWFT output word
// ----------------------------------------------------------------------------
module ipml_sync_fifo_v2
    import ipml_fifo_pkg::*;
#(
    parameter int    c_DEPTH_WIDTH      = 9,
    parameter int    c_DATA_WIDTH       = 32,
    parameter string c_MODE             = MODE_STD,
    parameter int    c_ALMOST_FULL_NUM  = 508,
    parameter int    c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [c_DEPTH_WIDTH:0]   water_level
);

    localparam int            AW      = c_DEPTH_WIDTH;
    localparam int            LW      = level_width(c_DEPTH_WIDTH);
    localparam bit            IS_FWFT = (c_MODE == MODE_FWFT);
    localparam logic [LW-1:0] DEPTH_L = LW'(2**c_DEPTH_WIDTH);
    localparam logic [LW-1:0] AF_L    = LW'(c_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_L    = LW'(c_ALMOST_EMPTY_NUM);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] mem_cnt_q, mem_cnt_d;   // words in RAM, FWFT only
    logic          out_valid_q, out_valid_d;
    logic          wr_full_q, wr_full_d, almost_full_q, almost_full_d;
    logic          rd_empty_q, rd_empty_d, almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic          wr_acc, rd_acc, fetch, ram_re;

    always_comb begin
        wr_acc = wr_en && !wr_full_q && !clr;
        rd_acc = rd_en && !rd_empty_q && !clr;
        // FWFT prefetch refills the output word when it is free or being
        // acknowledged; mem_cnt > 0 guarantees the fetched slot was written
        // on an earlier edge, so RAM read and write never collide.
        fetch  = IS_FWFT && (mem_cnt_q != '0) && (!out_valid_q || rd_acc) && !clr;
        ram_re = IS_FWFT ? fetch : rd_acc;

        level_d = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LW'(1);
        end

        mem_cnt_d = '0;
        if (IS_FWFT) begin
            mem_cnt_d = mem_cnt_q + LW'(wr_acc) - LW'(fetch);
        end
        out_valid_d = IS_FWFT && (fetch || (out_valid_q && !rd_acc));

        wr_ptr_d    = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d    = rd_ptr_q + AW'(ram_re);
        overflow_d  = overflow_q  | (wr_en && wr_full_q);
        underflow_d = underflow_q | (rd_en && rd_empty_q);

        if (clr) begin
            level_d     = '0;
            mem_cnt_d   = '0;
            out_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        // Flags derive from the next level so they move on the same edge.
        wr_full_d      = (level_d == DEPTH_L);
        almost_full_d  = (level_d >= AF_L);
        almost_empty_d = (level_d <= AE_L);
        rd_empty_d     = IS_FWFT ? !out_valid_d : (level_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            mem_cnt_q      <= '0;
            out_valid_q    <= 1'b0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            mem_cnt_q      <= mem_cnt_d;
            out_valid_q    <= out_valid_d;
            wr_full_q      <= wr_full_d;
            almost_full_q  <= almost_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // The RAM output register doubles as rd_data in both modes.
    ipml_sync_fifo_ram #(
        .AW (AW),
        .DW (c_DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clr),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign wr_full      = wr_full_q;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign rd_empty     = rd_empty_q;
    assign almost_empty = almost_empty_q;
    assign underflow    = underflow_q;
    assign water_level  = level_q;

endmodule
